// File: rtl/node_feeder_4_if.sv
// Handshake bundle for node_feeder_4: serial activation input and result output.
interface node_feeder_4_if #(
  parameter int DW = 8
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/node_feeder_4.sv
// Serial-to-parallel activation feeder for one layer-4 node; waits out the node latency and returns its result.
// Optional 16-bit saturating frame counter enabled by NODE_FEEDER_FRAME_CNT_EN.
module node_feeder_4 #(
  parameter int N_IN     = 15,
  parameter int DW       = 8,
  parameter int NODE_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  node_feeder_4_if.slave     io,
  output logic [N_IN*DW-1:0] a_bus,
  input  logic [DW-1:0]      node_res,
`ifdef NODE_FEEDER_FRAME_CNT_EN
  output logic [15:0]        frame_cnt,
`endif
  output logic               busy
);
  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WW = $clog2(NODE_LAT) + 1;

  typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] slot [N_IN];
  logic [DW-1:0] m_data_q;
  logic          m_valid_q;
  logic          accept, capture, done_out, last_slot;

  assign last_slot  = (cnt == CW'(N_IN - 1));
  // s_ready is gated by reset so nothing is acknowledged while the frame is being aborted
  assign io.s_ready = reset && (state == LOAD);
  assign io.m_data  = m_data_q;
  assign io.m_valid = m_valid_q;
  assign busy       = (state == WAIT) || (state == OUT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done_out  = 1'b0;
    case (state)
      LOAD: if (io.s_valid) begin
        accept = 1'b1;
        if (last_slot) state_nxt = WAIT;
      end
      WAIT: if (wcnt == WW'(NODE_LAT - 1)) begin
        capture   = 1'b1;
        state_nxt = OUT;
      end
      OUT: if (io.m_ready) begin
        done_out  = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      wcnt      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      for (int unsigned k = 0; k < N_IN; k++) slot[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        slot[cnt] <= io.s_data;
        cnt       <= last_slot ? '0 : cnt + 1'b1;
        if (last_slot) wcnt <= '0;
      end
      if (state == WAIT && !capture) wcnt <= wcnt + 1'b1;
      if (capture) begin
        m_data_q  <= node_res;
        m_valid_q <= 1'b1;
      end
      if (done_out) m_valid_q <= 1'b0;
    end
  end

  always_comb begin
    a_bus = '0;
    for (int unsigned k = 0; k < N_IN; k++) a_bus[k*DW +: DW] = slot[k];
  end

`ifdef NODE_FEEDER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          frame_cnt <= '0;
    else if (done_out && frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_node_feeder_4.sv
// Randomized self-checking bench for node_feeder_4 against a frame-level reference model.
module tb_node_feeder_4;
  localparam int N_IN = 15;
  localparam int DW   = 8;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [N_IN*DW-1:0]   a_bus;
  logic [DW-1:0]        node_res;
  logic                 busy;
  logic [DW-1:0]        p1 = '0, p2 = '0;
`ifdef NODE_FEEDER_FRAME_CNT_EN
  logic [15:0]          frame_cnt;
`endif

  node_feeder_4_if #(.DW(DW)) bus ();

  node_feeder_4 #(.N_IN(N_IN), .DW(DW), .NODE_LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .io       (bus.slave),
    .a_bus    (a_bus),
    .node_res (node_res),
`ifdef NODE_FEEDER_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy     (busy)
  );

  // Node stand-in: XOR of all slots, result present at the LAT-th edge after the bus settles
  function automatic logic [DW-1:0] bus_xor(input logic [N_IN*DW-1:0] b);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < N_IN; k++) r ^= b[k*DW +: DW];
    return r;
  endfunction

  always @(posedge clk) begin
    p1 <= bus_xor(a_bus);
    p2 <= p1;
  end
  assign node_res = p2;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slot contents, fill position, remaining latency, pending result
  logic [DW-1:0] m_slot [N_IN];
  int            fill, lat_left, frames;
  bit            out_pend;
  logic [DW-1:0] exp_md;

  task automatic model_reset();
    for (int k = 0; k < N_IN; k++) m_slot[k] = '0;
    fill = 0; lat_left = 0; out_pend = 0; exp_md = '0; frames = 0;
  endtask

  function automatic logic [N_IN*DW-1:0] model_bus();
    logic [N_IN*DW-1:0] r = '0;
    for (int k = 0; k < N_IN; k++) r[k*DW +: DW] = m_slot[k];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_xor();
    logic [DW-1:0] r = '0;
    for (int k = 0; k < N_IN; k++) r ^= m_slot[k];
    return r;
  endfunction

  task automatic tick();
    bit loading;
    @(negedge clk);
    loading = (lat_left == 0) && !out_pend;
    check_eq("a_bus",   a_bus,       model_bus());
    check_eq("s_ready", bus.s_ready, loading);
    check_eq("busy",    busy,        !loading);
    check_eq("m_valid", bus.m_valid, out_pend);
    check_eq("m_data",  bus.m_data,  exp_md);
`ifdef NODE_FEEDER_FRAME_CNT_EN
    check_eq("frame_cnt", frame_cnt, frames);
`endif
    if (loading) begin
      if (bus.s_valid) begin
        m_slot[fill] = bus.s_data;
        fill++;
        if (fill == N_IN) begin fill = 0; lat_left = LAT; end
      end
    end else if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin out_pend = 1; exp_md = model_xor(); end
    end else if (bus.m_ready) begin
      out_pend = 0;
      if (frames < 65535) frames++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] v [N_IN], input int gap_a, input int gap_b);
    for (int k = 0; k < N_IN; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = v[k];
      tick();
      if (k == gap_a || k == gap_b) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        repeat (2) tick();
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 30;
    bus.m_ready = 1'b1;
    tick();
    while (!bus.s_ready && budget > 0) begin tick(); budget--; end
    check_eq("drain_ready", bus.s_ready, 1'b1);
  endtask

  logic [DW-1:0] v [N_IN];

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    reset = 1'b0;
    model_reset();

    // Reset held, then idle
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_s_ready", bus.s_ready, 1'b0);
      check_eq("rst_a_bus",   a_bus,       '0);
      check_eq("rst_m_valid", bus.m_valid, 1'b0);
      check_eq("rst_busy",    busy,        1'b0);
    end
    @(posedge clk); #1; reset = 1'b1;
    repeat (10) tick();

    // Back-to-back frame k+1, result taken immediately
    for (int k = 0; k < N_IN; k++) v[k] = 8'(k + 1);
    bus.m_ready = 1'b1;
    send_frame(v, -1, -1);
    drain();

    // Input gaps after samples 4 and 9, result held 5 cycles
    for (int k = 0; k < N_IN; k++) v[k] = 8'($urandom);
    bus.m_ready = 1'b0;
    send_frame(v, 3, 8);
    begin
      int budget = 10;
      while (!bus.m_valid && budget > 0) begin tick(); budget--; end
      check_eq("stall_m_valid", bus.m_valid, 1'b1);
    end
    repeat (5) tick();
    drain();

    // Signed patterns after an all-0x55 frame
    for (int k = 0; k < N_IN; k++) v[k] = 8'h55;
    send_frame(v, -1, -1);
    drain();
    for (int k = 0; k < N_IN; k++) v[k] = 8'h00;
    v[0] = 8'h80; v[1] = 8'hFF; v[2] = 8'h7F;
    send_frame(v, -1, -1);
    drain();

    // Abort during WAIT, then a fresh frame must start in slot 0
    for (int k = 0; k < N_IN; k++) v[k] = 8'($urandom);
    send_frame(v, -1, -1);
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("abort_a_bus",   a_bus,       '0);
    check_eq("abort_m_valid", bus.m_valid, 1'b0);
    check_eq("abort_s_ready", bus.s_ready, 1'b0);
    check_eq("abort_busy",    busy,        1'b0);
    @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < N_IN; k++) v[k] = 8'(8'hA0 + k);
    send_frame(v, -1, -1);
    drain();

`ifdef NODE_FEEDER_FRAME_CNT_EN
    // Saturation of the frame counter
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    frames = 65535;
    for (int k = 0; k < N_IN; k++) v[k] = 8'($urandom);
    send_frame(v, -1, -1);
    drain();
    check_eq("frame_cnt_sat", frame_cnt, 16'hFFFF);
`endif

    // Random traffic on both handshakes
    for (int c = 0; c < 1500; c++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.s_data  = 8'($urandom);
      bus.m_ready = $urandom_range(0, 1);
      tick();
    end
    bus.s_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
